// File: rtl/arb_pkg.sv
// Shared arbiter definitions: default requester count and a one-hot to
// binary index helper reused by the arbiter family.
package arb_pkg;

    localparam int ARB_N_DEFAULT = 4;

    // Widest request vector onehot2idx accepts; narrower vectors are zero-extended.
    localparam int ARB_MAX_N = 64;

    function automatic int onehot2idx(input logic [ARB_MAX_N-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority winner search: descending from prio with
// wrap to N-1, done as a masked search (indices <= prio) falling back to the full vector.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] prio_i,
    output logic [N-1:0]     win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_o
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] cand;
    logic         found;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i <= int'(prio_i));
        end
    end

    assign masked = req_i & mask;
    // Nothing at or below prio means the winner lies above it; the top of the full vector is then next in line.
    assign cand   = (|masked) ? masked : req_i;
    assign any_o  = |req_i;

    always_comb begin
        win_oh_o = '0;
        found    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i] && !found) begin
                win_oh_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign win_idx_o = IDX_W'(onehot2idx(ARB_MAX_N'(win_oh_o)));

endmodule

// File: rtl/rr_arb.sv
// N-requester round-robin arbiter with registered one-hot grant and index.
// Define RR_ARB_LOCK_EN to add the lock input that lets a grantee hold its grant.
module rr_arb
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             en,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             req_up
);

    localparam logic [IDX_W-1:0] PRIO_TOP = IDX_W'(N - 1);

    logic [N-1:0]     gnt_q,     gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] prio_q,    prio_d;

    logic [N-1:0]     win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic             hold;

    rr_pick #(.N(N)) u_pick (
        .req_i     (req),
        .prio_i    (prio_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .any_o     (any_req)
    );

`ifdef RR_ARB_LOCK_EN
    // gnt_q is one-hot or zero, so this tests the current grantee's own request.
    assign hold = en & lock & (|(req & gnt_q));
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        prio_d    = prio_q;
        if (!hold) begin
            if (en && any_req) begin
                gnt_d     = win_oh;
                gnt_idx_d = win_idx;
                prio_d    = (win_idx == '0) ? PRIO_TOP : win_idx - IDX_W'(1);
            end else begin
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            prio_q    <= PRIO_TOP;
        end else begin
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            prio_q    <= prio_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign req_up  = any_req;

endmodule

// File: tb/tb_rr_arb.sv
// Bench for rr_arb: directed vector table, hand-written corner sequences and a
// randomized phase checked against a search-order reference model (N=4 and N=3).
module tb_rr_arb;

`ifdef RR_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req4;
    logic [2:0] req3;
    logic       en;
    logic       lock;
    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       up4;
    logic [2:0] gnt3;
    logic [1:0] idx3;
    logic       up3;

    int total = 0;
    int bad   = 0;

    int mp4, mw4, mp3, mw3;
    bit mv4, mv3;

    always #5 clock = ~clock;

    rr_arb #(.N(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req4),
        .en      (en),
`ifdef RR_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt4),
        .gnt_idx (idx4),
        .req_up  (up4)
    );

    rr_arb #(.N(3)) dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req3),
        .en      (en),
`ifdef RR_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt3),
        .gnt_idx (idx3),
        .req_up  (up3)
    );

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       en;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       up;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Walk the requesters in priority order prio, prio-1, ..., wrapping mod n.
    function automatic void arb_step(input int n, input logic [7:0] r, input logic e,
                                     input logic lk, inout int prio, inout int w, inout bit v);
        int c;
        if (e && lk && v && r[w]) return;
        v = 1'b0;
        w = 0;
        if (!e) return;
        for (int k = 0; k < n; k++) begin
            c = (prio - k + n) % n;
            if (r[c]) begin
                w    = c;
                v    = 1'b1;
                prio = (c == 0) ? n - 1 : c - 1;
                return;
            end
        end
    endfunction

    function automatic logic [31:0] oh(input int w, input bit v);
        return v ? (32'd1 << w) : 32'd0;
    endfunction

    task automatic model_reset();
        mp4 = 3; mw4 = 0; mv4 = 1'b0;
        mp3 = 2; mw3 = 0; mv3 = 1'b0;
    endtask

    task automatic cyc(input bit cmp);
        arb_step(4, {4'b0, req4}, en, lock && LOCK_ON, mp4, mw4, mv4);
        arb_step(3, {5'b0, req3}, en, lock && LOCK_ON, mp3, mw3, mv3);
        @(posedge clock);
        #1;
        if (cmp) begin
            check("rnd_gnt4", 32'(gnt4), oh(mw4, mv4));
            check("rnd_idx4", 32'(idx4), mv4 ? 32'(mw4) : 32'd0);
            check("rnd_up4",  32'(up4),  32'(|req4));
            check("rnd_gnt3", 32'(gnt3), oh(mw3, mv3));
            check("rnd_idx3", 32'(idx3), mv3 ? 32'(mw3) : 32'd0);
            check("rnd_up3",  32'(up3),  32'(|req3));
        end
    endtask

    // Assert reset between edges, check the cleared outputs, release away from an edge.
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt4", 32'(gnt4), 32'd0);
        check("rst_idx4", 32'(idx4), 32'd0);
        check("rst_gnt3", 32'(gnt3), 32'd0);
        check("rst_up4",  32'(up4),  32'(|req4));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic void add(input bit rst, input logic [3:0] r, input logic e,
                                input logic [3:0] g, input logic [1:0] i, input logic u);
        vec_t v;
        v.rst = rst; v.req = r; v.en = e; v.gnt = g; v.idx = i; v.up = u;
        tv.push_back(v);
    endfunction

    initial begin
        logic [2:0] exp3 [4];
        logic [1:0] expi3[4];

        reset_n = 1'b0;
        req4 = '0; req3 = '0; en = 1'b1; lock = 1'b0;
        model_reset();
        #2;

        // round robin from reset
        add(1, 4'b1111, 1, 4'b1000, 2'd3, 1);
        add(0, 4'b1111, 1, 4'b0100, 2'd2, 1);
        add(0, 4'b1111, 1, 4'b0010, 2'd1, 1);
        add(0, 4'b1111, 1, 4'b0001, 2'd0, 1);
        add(0, 4'b1111, 1, 4'b1000, 2'd3, 1);
        // sparse requests
        add(1, 4'b0101, 1, 4'b0100, 2'd2, 1);
        add(0, 4'b0101, 1, 4'b0001, 2'd0, 1);
        add(0, 4'b0101, 1, 4'b0100, 2'd2, 1);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 0);
        // enable gating preserves prio
        add(1, 4'b1111, 1, 4'b1000, 2'd3, 1);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 1);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 1);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 1);
        add(0, 4'b1111, 1, 4'b0100, 2'd2, 1);

        foreach (tv[i]) begin
            if (tv[i].rst) do_reset();
            req4 = tv[i].req;
            en   = tv[i].en;
            lock = 1'b0;
            req3 = '0;
            cyc(0);
            check($sformatf("vec%0d_gnt", i), 32'(gnt4),   32'(tv[i].gnt));
            check($sformatf("vec%0d_idx", i), 32'(idx4),   32'(tv[i].idx));
            check($sformatf("vec%0d_up", i),  32'(up4),    32'(tv[i].up));
        end

        // req_up is combinational
        req4 = 4'b0110;
        #1;
        check("up_comb_hi", 32'(up4), 32'd1);
        req4 = 4'b0000;
        #1;
        check("up_comb_lo", 32'(up4), 32'd0);
        @(posedge clock);
        #1;

        // async reset during grant 0010
        do_reset();
        req4 = 4'b1111; en = 1'b1;
        cyc(0); cyc(0); cyc(0);
        check("pre_arst_gnt", 32'(gnt4), 32'b0010);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt4), 32'd0);
        check("arst_idx", 32'(idx4), 32'd0);
        model_reset();
        #2;
        reset_n = 1'b1;
        cyc(0);
        check("post_arst_gnt", 32'(gnt4), 32'b1000);
        check("post_arst_idx", 32'(idx4), 32'd3);

`ifdef RR_ARB_LOCK_EN
        do_reset();
        req4 = 4'b1001; lock = 1'b0;
        cyc(0);
        check("lock_first", 32'(gnt4), 32'b1000);
        lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(0);
            check($sformatf("lock_hold%0d", k), 32'(gnt4), 32'b1000);
            check($sformatf("lock_idx%0d", k),  32'(idx4), 32'd3);
        end
        req4 = 4'b0001;
        cyc(0);
        check("lock_drop", 32'(gnt4), 32'b0001);
        lock = 1'b0;
`endif

        // non-power-of-two
        exp3[0] = 3'b100; exp3[1] = 3'b010; exp3[2] = 3'b001; exp3[3] = 3'b100;
        expi3[0] = 2'd2;  expi3[1] = 2'd1;  expi3[2] = 2'd0;  expi3[3] = 2'd2;
        do_reset();
        req4 = '0; req3 = 3'b111; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(0);
            check($sformatf("n3_gnt%0d", k), 32'(gnt3), 32'(exp3[k]));
            check($sformatf("n3_idx%0d", k), 32'(idx3), 32'(expi3[k]));
            check($sformatf("n3_idx_ne3_%0d", k), 32'(idx3 != 2'd3), 32'd1);
        end

        // randomized against the reference model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (k % 150 == 149) do_reset();
            req4 = 4'($urandom);
            req3 = 3'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            lock = 1'($urandom_range(0, 1));
            cyc(1);
            check("rnd_idx3_range", 32'(idx3 != 2'd3), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
